// File: rtl/mda_crtc.sv
// MDA-style 6845 CRTC register file: I/O decode, cursor/blink control, double-buffered addresses.
// Optional build macro MDA_CRTC_READBACK_EN adds readback of R10-R13 and the mode register.
module mda_crtc (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [15:0] iIoAddr,
  input  logic [7:0]  iIoData,
  input  logic        iIoWr,
  input  logic        iIoRd,
  output logic [7:0]  oIoData,
  output logic        oIoSel,
  input  logic        iVSync,
  input  logic        iBlank,
  output logic [13:0] oStartAddr,
  output logic [13:0] oCursorAddr,
  output logic [4:0]  oCursorStart,
  output logic [4:0]  oCursorEnd,
  output logic        oCursorOn,
  output logic        oVideoEn,
  output logic        oBlinkEn
);

  logic       is_index, is_data, is_mode, is_status, vsync_rise;
  logic [4:0] index_q, index_d;
  // Only R10-R15 affect outputs or reads; writes to the other valid indices are discarded.
  logic [6:0] r10_q, r10_d;
  logic [4:0] r11_q, r11_d;
  logic [5:0] r12_q, r12_d, r14_q, r14_d;
  logic [7:0] r13_q, r13_d, r15_q, r15_d;
`ifdef MDA_CRTC_READBACK_EN
  logic [7:0] mode_q, mode_d;
  assign oVideoEn = mode_q[3];
  assign oBlinkEn = mode_q[5];
`else
  logic [1:0] mode_q, mode_d;  // {bit5, bit3}
  assign oVideoEn = mode_q[0];
  assign oBlinkEn = mode_q[1];
`endif
  logic [4:0]  blink_cnt_q;
  logic        vsync_q;
  logic [13:0] start_q, cursor_q;
  logic [7:0]  io_data_q, rd_data;
  logic        io_sel_q, rd_sel, blink_ok;

  assign is_index   = (iIoAddr[15:3] == 13'h0076) & ~iIoAddr[0];
  assign is_data    = (iIoAddr[15:3] == 13'h0076) & iIoAddr[0];
  assign is_mode    = (iIoAddr == 16'h03B8);
  assign is_status  = (iIoAddr == 16'h03BA);
  assign vsync_rise = iVSync & ~vsync_q;

  always_comb begin
    index_d = index_q;
    r10_d   = r10_q;
    r11_d   = r11_q;
    r12_d   = r12_q;
    r13_d   = r13_q;
    r14_d   = r14_q;
    r15_d   = r15_q;
    mode_d  = mode_q;
    if (iIoWr) begin
      if (is_index) index_d = iIoData[4:0];
      if (is_data) begin
        case (index_q)
          5'd10:   r10_d = iIoData[6:0];
          5'd11:   r11_d = iIoData[4:0];
          5'd12:   r12_d = iIoData[5:0];
          5'd13:   r13_d = iIoData;
          5'd14:   r14_d = iIoData[5:0];
          5'd15:   r15_d = iIoData;
          default: ;
        endcase
      end
`ifdef MDA_CRTC_READBACK_EN
      if (is_mode) mode_d = iIoData;
`else
      if (is_mode) mode_d = {iIoData[5], iIoData[3]};
`endif
    end
  end

  // Read mux sees pre-write state, so a simultaneous write is not visible to the read.
  always_comb begin
    rd_sel  = 1'b1;
    rd_data = 8'h00;
    if (is_index) begin
      rd_data = {3'b000, index_q};
    end else if (is_data) begin
      case (index_q)
`ifdef MDA_CRTC_READBACK_EN
        5'd10:   rd_data = {1'b0, r10_q};
        5'd11:   rd_data = {3'b000, r11_q};
        5'd12:   rd_data = {2'b00, r12_q};
        5'd13:   rd_data = r13_q;
`endif
        5'd14:   rd_data = {2'b00, r14_q};
        5'd15:   rd_data = r15_q;
        default: rd_data = 8'h00;
      endcase
    end else if (is_mode) begin
`ifdef MDA_CRTC_READBACK_EN
      rd_data = mode_q;
`else
      rd_data = 8'hFF;
`endif
    end else if (is_status) begin
      rd_data = {4'hF, iVSync, 2'b00, iBlank};
    end else begin
      rd_sel = 1'b0;
    end
  end

  // Blink phases: visible while the selected counter bit is low.
  always_comb begin
    blink_ok = 1'b1;
    case (r10_q[6:5])
      2'b00:   blink_ok = 1'b1;
      2'b01:   blink_ok = 1'b0;
      2'b10:   blink_ok = ~blink_cnt_q[3];
      default: blink_ok = ~blink_cnt_q[4];
    endcase
  end

  assign oCursorOn    = blink_ok & oVideoEn & (r11_q >= r10_q[4:0]);
  assign oCursorStart = r10_q[4:0];
  assign oCursorEnd   = r11_q;
  assign oStartAddr   = start_q;
  assign oCursorAddr  = cursor_q;
  assign oIoData      = io_data_q;
  assign oIoSel       = io_sel_q;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      index_q     <= '0;
      r10_q       <= 7'h0B;
      r11_q       <= 5'h0C;
      r12_q       <= '0;
      r13_q       <= '0;
      r14_q       <= '0;
      r15_q       <= '0;
      mode_q      <= '0;
      blink_cnt_q <= '0;
      vsync_q     <= 1'b0;
      start_q     <= '0;
      cursor_q    <= '0;
      io_data_q   <= '0;
      io_sel_q    <= 1'b0;
    end else begin
      index_q <= index_d;
      r10_q   <= r10_d;
      r11_q   <= r11_d;
      r12_q   <= r12_d;
      r13_q   <= r13_d;
      r14_q   <= r14_d;
      r15_q   <= r15_d;
      mode_q  <= mode_d;
      vsync_q <= iVSync;
      // Latch from next-state so a write on the edge cycle is shown this frame.
      if (vsync_rise) begin
        blink_cnt_q <= blink_cnt_q + 5'd1;
        start_q     <= {r12_d, r13_d};
        cursor_q    <= {r14_d, r15_d};
      end
      if (iIoRd) begin
        io_data_q <= rd_data;
        io_sel_q  <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_mda_crtc.sv
// Randomized self-checking bench for mda_crtc against a frame/register-level behavioural model.
module tb_mda_crtc;

  logic        iClk, iRstN;
  logic [15:0] iIoAddr;
  logic [7:0]  iIoData;
  logic        iIoWr, iIoRd, iVSync, iBlank;
  logic [7:0]  oIoData;
  logic        oIoSel;
  logic [13:0] oStartAddr, oCursorAddr;
  logic [4:0]  oCursorStart, oCursorEnd;
  logic        oCursorOn, oVideoEn, oBlinkEn;

  mda_crtc dut (
    .iClk(iClk), .iRstN(iRstN), .iIoAddr(iIoAddr), .iIoData(iIoData), .iIoWr(iIoWr),
    .iIoRd(iIoRd), .oIoData(oIoData), .oIoSel(oIoSel), .iVSync(iVSync), .iBlank(iBlank),
    .oStartAddr(oStartAddr), .oCursorAddr(oCursorAddr), .oCursorStart(oCursorStart),
    .oCursorEnd(oCursorEnd), .oCursorOn(oCursorOn), .oVideoEn(oVideoEn), .oBlinkEn(oBlinkEn)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  // Behavioural model state
  int m_r[0:17];
  int m_idx, m_mode, m_frames, m_start, m_cursor, m_rdata;
  bit m_rsel, m_vs_prev;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int reg_mask(input int idx);
    case (idx)
      10:      return 127;
      11:      return 31;
      12, 14:  return 63;
      default: return 255;
    endcase
  endfunction

  function automatic int exp_cursor_on();
    int blink;
    case (m_r[10] / 32)
      0:       blink = 1;
      1:       blink = 0;
      2:       blink = ((m_frames / 8) % 2 == 0) ? 1 : 0;
      default: blink = (m_frames < 16) ? 1 : 0;
    endcase
    if ((m_mode / 8) % 2 == 0) return 0;
    if (m_r[11] < m_r[10] % 32) return 0;
    return blink;
  endfunction

  task automatic model_step();
    int a, d;
    bit rise;
    if (!iRstN) begin
      m_idx = 0;
      for (int i = 0; i < 18; i++) m_r[i] = 0;
      m_r[10] = 11;
      m_r[11] = 12;
      m_mode = 0; m_frames = 0; m_vs_prev = 0; m_rdata = 0; m_rsel = 0;
      m_start = 0; m_cursor = 0;
      return;
    end
    a = int'(iIoAddr);
    d = int'(iIoData);
    rise = iVSync && !m_vs_prev;
    if (iIoRd) begin
      m_rsel = 1;
      m_rdata = 0;
      if (a >= 'h3B0 && a <= 'h3B7 && a % 2 == 0) m_rdata = m_idx;
      else if (a >= 'h3B0 && a <= 'h3B7) begin
        if (m_idx == 14 || m_idx == 15) m_rdata = m_r[m_idx];
`ifdef MDA_CRTC_READBACK_EN
        else if (m_idx >= 10 && m_idx <= 13) m_rdata = m_r[m_idx];
`endif
      end else if (a == 'h3B8) begin
`ifdef MDA_CRTC_READBACK_EN
        m_rdata = m_mode;
`else
        m_rdata = 255;
`endif
      end else if (a == 'h3BA) m_rdata = 240 + (iVSync ? 8 : 0) + (iBlank ? 1 : 0);
      else m_rsel = 0;
    end
    if (iIoWr) begin
      if (a >= 'h3B0 && a <= 'h3B7 && a % 2 == 0) m_idx = d % 32;
      else if (a >= 'h3B0 && a <= 'h3B7) begin
        if (m_idx <= 17) m_r[m_idx] = d & reg_mask(m_idx);
      end else if (a == 'h3B8) m_mode = d;
    end
    if (rise) begin
      m_frames = (m_frames + 1) % 32;
      m_start  = m_r[12] * 256 + m_r[13];
      m_cursor = m_r[14] * 256 + m_r[15];
    end
    m_vs_prev = iVSync;
  endtask

  initial forever begin
    @(posedge iClk);
    model_step();
  end

  // Every-cycle compare, sampled on the falling edge
  initial forever begin
    @(negedge iClk);
    if (chk_en) begin
      chk("io_data", int'(oIoData), m_rdata);
      chk("io_sel", int'(oIoSel), int'(m_rsel));
      chk("start_addr", int'(oStartAddr), m_start);
      chk("cursor_addr", int'(oCursorAddr), m_cursor);
      chk("cursor_start", int'(oCursorStart), m_r[10] % 32);
      chk("cursor_end", int'(oCursorEnd), m_r[11]);
      chk("cursor_on", int'(oCursorOn), exp_cursor_on());
      chk("video_en", int'(oVideoEn), (m_mode / 8) % 2);
      chk("blink_en", int'(oBlinkEn), (m_mode / 32) % 2);
    end
  end

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    iIoAddr = a; iIoData = d; iIoWr = 1'b1;
    @(negedge iClk);
    iIoWr = 1'b0;
  endtask

  task automatic io_rd(input logic [15:0] a);
    iIoAddr = a; iIoRd = 1'b1;
    @(negedge iClk);
    iIoRd = 1'b0;
  endtask

  task automatic vs_pulse();
    iVSync = 1'b1;
    @(negedge iClk);
    iVSync = 1'b0;
    @(negedge iClk);
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    repeat (2) @(negedge iClk);
    iRstN = 1'b1;
  endtask

  initial begin
    int sel, exp;
    iRstN = 1'b0; iIoAddr = '0; iIoData = '0; iIoWr = 0; iIoRd = 0; iVSync = 0; iBlank = 0;
    repeat (2) @(negedge iClk);
    chk_en = 1;
    iRstN = 1'b1;
    chk("lit_rst_cstart", int'(oCursorStart), 'h0B);
    chk("lit_rst_cend", int'(oCursorEnd), 'h0C);
    chk("lit_rst_sel", int'(oIoSel), 0);

    // Cursor address write/readback and vsync-buffered output
    io_wr(16'h3B4, 8'h0E); io_wr(16'h3B5, 8'h12);
    io_wr(16'h3B4, 8'h0F); io_wr(16'h3B5, 8'h34);
    io_rd(16'h3B5);
    chk("lit_rd_r15", int'(oIoData), 'h34);
    io_wr(16'h3B4, 8'h0E);
    io_rd(16'h3B5);
    chk("lit_rd_r14", int'(oIoData), 'h12);
    chk("lit_caddr_pre", int'(oCursorAddr), 0);
    vs_pulse();
    chk("lit_caddr_post", int'(oCursorAddr), 'h1234);

    // Status port
    iVSync = 1'b1; iBlank = 1'b1;
    io_rd(16'h3BA);
    chk("lit_status_f9", int'(oIoData), 'hF9);
    iVSync = 1'b0; iBlank = 1'b0;
    io_rd(16'h3BA);
    chk("lit_status_f0", int'(oIoData), 'hF0);

    // Blink modes over 32 frames each
    do_reset();
    io_wr(16'h3B8, 8'h08);
    io_wr(16'h3B4, 8'h0A); io_wr(16'h3B5, 8'h40);
    for (int f = 0; f < 32; f++) begin
      exp = ((f >= 8 && f < 16) || f >= 24) ? 0 : 1;
      chk("lit_blink16", int'(oCursorOn), exp);
      vs_pulse();
    end
    io_wr(16'h3B5, 8'h60);
    for (int f = 0; f < 32; f++) begin
      chk("lit_blink32", int'(oCursorOn), (f >= 16) ? 0 : 1);
      vs_pulse();
    end

    // Out-of-range index and undecoded port
    io_wr(16'h3B4, 8'h14); io_wr(16'h3B5, 8'hAA);
    io_rd(16'h3B1);
    chk("lit_rd_idx20", int'(oIoData), 0);
    io_rd(16'h3C0);
    chk("lit_sel_3c0", int'(oIoSel), 0);

    // Start address written on the vsync edge cycle
    io_wr(16'h3B4, 8'h0C); io_wr(16'h3B5, 8'h3F);
    io_wr(16'h3B4, 8'h0D);
    iVSync = 1'b1;
    io_wr(16'h3B5, 8'hFF);
    iVSync = 1'b0;
    chk("lit_saddr_edge", int'(oStartAddr), 'h3FFF);

    // Reset during a write/read
    io_rd(16'h3BA);
    iRstN = 1'b0; iIoAddr = 16'h3B5; iIoData = 8'h55; iIoWr = 1'b1; iIoRd = 1'b1;
    @(negedge iClk);
    iIoWr = 1'b0; iIoRd = 1'b0; iRstN = 1'b1;
    chk("lit_rst_mid_sel", int'(oIoSel), 0);
    chk("lit_rst_mid_saddr", int'(oStartAddr), 0);
    chk("lit_rst_mid_cend", int'(oCursorEnd), 'h0C);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sel = $urandom_range(0, 15);
      if (sel < 8) iIoAddr = 16'(16'h3B0 + sel);
      else if (sel < 11) iIoAddr = 16'h3B8;
      else if (sel < 13) iIoAddr = 16'h3BA;
      else if (sel == 13) iIoAddr = 16'h3B9;
      else if (sel == 14) iIoAddr = 16'h3C0;
      else iIoAddr = 16'($urandom_range(0, 65535));
      iIoData = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'(10 + $urandom_range(0, 7));
      iIoWr  = ($urandom_range(0, 2) == 0);
      iIoRd  = ($urandom_range(0, 2) == 0);
      iBlank = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 5) == 0) iVSync = ~iVSync;
      iRstN  = ($urandom_range(0, 399) != 0);
      @(negedge iClk);
    end
    iIoWr = 1'b0; iIoRd = 1'b0; iRstN = 1'b1;
    @(negedge iClk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mda_crtc.md
MDA_CRTC -- requirements
Module: mda_crtc

Interface
REQ-001 iClk  input  1  CPU-domain clock; all state changes on its rising edge.
REQ-002 iRstN  input  1  reset; synchronous, active-low.
REQ-003 iIoAddr  input  16  I/O port address.
REQ-004 iIoData  input  8  I/O write data.
REQ-005 iIoWr  input  1  I/O write strobe, one cycle per access.
REQ-006 iIoRd  input  1  I/O read strobe, one cycle per access.
REQ-007 oIoData  output  8  registered read data.
REQ-008 oIoSel  output  1  registered high when the read in the previous cycle decoded to this block.
REQ-009 iVSync  input  1  vertical sync from the video generator, already synchronous to iClk, active-high.
REQ-010 iBlank  input  1  video blanking flag, already synchronous to iClk.
REQ-011 oStartAddr  output  14  display start address {R12[5:0],R13}.
REQ-012 oCursorAddr  output  14  cursor address {R14[5:0],R15}.
REQ-013 oCursorStart / oCursorEnd  output  5 each  cursor scanlines R10[4:0] / R11[4:0].
REQ-014 oCursorOn  output  1  cursor visible this frame.
REQ-015 oVideoEn / oBlinkEn  output  1 each  mode-control bits 3 / 5.

Function
REQ-016 Decode: 0x3B0-0x3B7 even = index register, odd = data register (mirrored); 0x3B8 = mode control (write-only); 0x3BA = status (read-only); other ports are ignored, oIoSel=0.
REQ-017 Index write latches iIoData[4:0]; data write stores iIoData into register R[index] when index<=17, masked to the 6845 width (R12/R14: 6 bits, R10: 7 bits, R11: 5 bits); index 18-31 writes are dropped.
REQ-018 Reads: index port returns {3'b000,index}; data port returns R14/R15 (index 14/15), otherwise 0x00; status returns {4'hF,iVSync,2'b00,iBlank}; 0x3B8 returns 0xFF.
REQ-019 Read latency: oIoData/oIoSel valid exactly one cycle after iIoRd; held until the next read.
REQ-020 iIoRd and iIoWr asserted in the same cycle: the write takes effect, and the read returns pre-write data.
REQ-021 Blink counter: 5-bit frame counter, increments on each iVSync rising edge (one-cycle edge detect), wraps 31->0.
REQ-022 R10[6:5] cursor mode: 00 -> oCursorOn=1; 01 -> 0; 10 -> counter bit 3 (toggles every 8 frames, 16-frame period); 11 -> counter bit 4 (32-frame period).
REQ-023 oCursorOn additionally forced 0 when oVideoEn=0 or R11[4:0] < R10[4:0].
REQ-024 Register outputs update the cycle after the write; oStartAddr and oCursorAddr are double-buffered and take the shadow value only on the iVSync rising edge, so a frame never shows a half-written address.
REQ-025 Write to R12/R13/R14/R15 in the same cycle as the iVSync rising edge: the new value goes to the shadow register and the output uses the new value.

Reset
REQ-026 With iRstN=0 at a clock edge: index=0, all R=0 except R10=0x0B and R11=0x0C, mode=0x00, blink counter=0, edge detector=0, oIoData=0x00, oIoSel=0, output address buffers=0.
REQ-027 A reset asserted mid-access overrides the access; no write lands, and oIoSel=0 the next cycle.

Configuration
REQ-028 With MDA_CRTC_READBACK_EN defined, the data port also reads back R10-R13 (masked values) and 0x3B8 returns the mode register.
REQ-029 Without MDA_CRTC_READBACK_EN, REQ-018 applies unchanged.

Verification
REQ-030 Reset, then: index=0x0E, data=0x12, index=0x0F, data=0x34, read 0x3B5 -> 0x34; read again after index=0x0E -> 0x12; oCursorAddr=0x1234 only after the next iVSync rise.
REQ-031 Write 0x3B8=0x08 and R10=0x40 (mode 10); pulse iVSync 32 times -> oCursorOn low for frames 8-15 and 24-31, high otherwise; with R10=0x60, low for frames 16-31.
REQ-032 Status read with iVSync=1, iBlank=1 -> 0xF9; with both 0 -> 0xF0.
REQ-033 Index=0x14, data=0xAA -> R0-R17 unchanged; read 0x3B1 -> 0x00; read 0x3C0 -> oIoSel=0.
REQ-034 R12=0x3F, R13=0xFF written on the iVSync rising-edge cycle -> oStartAddr=0x3FFF the next cycle; assert iRstN=0 during a later write -> write lost, outputs return to reset values.
